put_sequencer: RTL

Instruction-side encoder for the accumulator "put" protocol. It accepts one operation bundle (an opcode byte plus zero to three operand bytes) over a valid/ready handshake. It then emits the bundle as a stream of 9-bit machine words: one put word per operand, followed by the opcode word. It sits between a program source (boot loader or test driver) and the instruction path that feeds the control decoder and the accumulator, and produces exactly the word sequence the accumulator consumes.

---
 rtl/put_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/put_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | put_sequencer: serialises an opcode plus 0..3 operands into put/opcode words |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module put_sequencer #(
  parameter int D  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_cnt,
  input  logic [D-1:0]  in_op,
  input  logic [D-1:0]  in_a0,
  input  logic [D-1:0]  in_a1,
  input  logic [D-1:0]  in_a2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D:0]    out_code,
  output logic          out_last,
  output logic          busy,
  output logic [CW-1:0] bundles
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PUT0 = 3'd1;
  localparam logic [2:0] c_PUT1 = 3'd2;
  localparam logic [2:0] c_PUT2 = 3'd3;
  localparam logic [2:0] c_OPC  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q;
  logic [D-1:0]  op_q, a0_q, a1_q, a2_q;
  logic [D:0]    code_q, code_d;
  logic          last_q, last_d;
  logic [CW-1:0] bundles_q;
  logic          w_hs;
  logic          w_accept;

  assign out_valid = (state_q != c_IDLE);
  assign w_hs      = out_valid && out_ready;
  // Accepting during the opcode handshake gives gapless back-to-back bundles.
  assign in_ready  = !reset && ((state_q == c_IDLE) || ((state_q == c_OPC) && out_ready));
  assign w_accept  = in_valid && in_ready;

  assign out_code = code_q;
  assign out_last = last_q;
  assign busy     = out_valid;
  assign bundles  = bundles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a0_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      code_q    <= '0;
      last_q    <= 1'b0;
      bundles_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      last_q  <= last_d;
      if (w_accept) begin
        cnt_q <= in_cnt;
        op_q  <= in_op;
        a0_q  <= in_a0;
        a1_q  <= in_a1;
        a2_q  <= in_a2;
      end
      if (w_hs && (state_q == c_OPC)) begin
        bundles_q <= bundles_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (w_accept) state_d = (in_cnt != 2'd0) ? c_PUT0 : c_OPC;
      c_PUT0: if (w_hs)     state_d = (cnt_q >= 2'd2) ? c_PUT1 : c_OPC;
      c_PUT1: if (w_hs)     state_d = (cnt_q == 2'd3) ? c_PUT2 : c_OPC;
      c_PUT2: if (w_hs)     state_d = c_OPC;
      c_OPC: begin
        if (w_hs) begin
          if (w_accept) state_d = (in_cnt != 2'd0) ? c_PUT0 : c_OPC;
          else          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // The word register is loaded with the word belonging to the next state.
  always_comb begin
    code_d = code_q;
    last_d = last_q;
    if (w_accept) begin
      code_d = (in_cnt != 2'd0) ? {1'b1, in_a0} : {1'b0, in_op};
      last_d = (in_cnt == 2'd0);
    end else if (w_hs) begin
      case (state_d)
        c_PUT1:  begin code_d = {1'b1, a1_q}; last_d = 1'b0; end
        c_PUT2:  begin code_d = {1'b1, a2_q}; last_d = 1'b0; end
        c_OPC:   begin code_d = {1'b0, op_q}; last_d = 1'b1; end
        default: begin code_d = '0;           last_d = 1'b0; end
      endcase
    end
  end

endmodule
`default_nettype wire
